// File: rtl/ctrl_sync_pkg.sv
// ctrl_sync_pkg: shared defaults and legal parameter ranges for the control synchroniser
package ctrl_sync_pkg;
    localparam int DEF_WIDTH         = 4;
    localparam int DEF_STAGES        = 2;
    localparam int DEF_STABLE_CYCLES = 4;
    localparam int STAGES_MIN        = 2;
    localparam int STAGES_MAX        = 4;
    localparam int STABLE_MIN        = 1;
    localparam int STABLE_MAX        = 255;
endpackage

// File: rtl/sync_chain.sv
// sync_chain: per-bit multi-flop synchroniser into the clkB domain
module sync_chain
    import ctrl_sync_pkg::*;
#(
    parameter int WIDTH  = DEF_WIDTH,
    parameter int STAGES = DEF_STAGES
) (
    input  logic             clkB,
    input  logic             rstB,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] s_o
);
    logic [STAGES-1:0][WIDTH-1:0] chain_q;
    // plain shift through the flop chain, nothing between stages
    always_ff @(posedge clkB or posedge rstB)
        if (rstB) chain_q <= '0;
        else      chain_q <= {chain_q[STAGES-2:0], d_i};
    assign s_o = chain_q[STAGES-1];
endmodule

// File: rtl/ctrl_sync_filter.sv
// ctrl_sync_filter: synchronises a control word and accepts it only once it has been stable
module ctrl_sync_filter
    import ctrl_sync_pkg::*;
#(
    parameter int WIDTH         = DEF_WIDTH,
    parameter int STAGES        = DEF_STAGES,
    parameter int STABLE_CYCLES = DEF_STABLE_CYCLES
) (
    input  logic             clkB,
    input  logic             rstB,
    input  logic [WIDTH-1:0] async_in,
    input  logic             filt_en,
    output logic [WIDTH-1:0] ctrl_out,
    output logic             ctrl_chg,
    output logic [WIDTH-1:0] ctrl_rise,
    output logic [WIDTH-1:0] ctrl_fall
);
    localparam int CW = $clog2(STABLE_CYCLES) + 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CYCLES - 1);

    if (STAGES < STAGES_MIN || STAGES > STAGES_MAX) begin : g_bad_stages
        $error("ctrl_sync_filter: STAGES must be within 2..4");
    end
    if (STABLE_CYCLES < STABLE_MIN || STABLE_CYCLES > STABLE_MAX) begin : g_bad_stable
        $error("ctrl_sync_filter: STABLE_CYCLES must be within 1..255");
    end

    logic [WIDTH-1:0] s;
    logic [WIDTH-1:0] cand_q, cand_d, out_q, out_d, rise_q, rise_d, fall_q, fall_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             chg_q, chg_d;

    sync_chain #(.WIDTH(WIDTH), .STAGES(STAGES)) u_sync (
        .clkB (clkB),
        .rstB (rstB),
        .d_i  (async_in),
        .s_o  (s)
    );

    // candidate tracking, stability count and acceptance; the word is accepted once the
    // candidate has been sampled STABLE_CYCLES times in a row, so a change arriving on the
    // accepting edge itself only restarts the count for the next word
    always_comb begin
        cand_d = cand_q;
        cnt_d  = cnt_q;
        out_d  = out_q;
        if (!filt_en) begin
            cand_d = s;
            cnt_d  = '0;
            out_d  = s;
        end else begin
            out_d = (cnt_q == CNT_MAX) ? cand_q : out_q;
            if (s != cand_q) begin
                cand_d = s;
                cnt_d  = '0;
            end else if (cnt_q != CNT_MAX) begin
                cnt_d = cnt_q + 1'b1;
            end
        end
        chg_d  = out_d != out_q;
        rise_d = out_d & ~out_q;
        fall_d = ~out_d & out_q;
    end

    // state and registered edge pulses, all cleared asynchronously
    always_ff @(posedge clkB or posedge rstB)
        if (rstB) begin
            cand_q <= '0;
            cnt_q  <= '0;
            out_q  <= '0;
            chg_q  <= 1'b0;
            rise_q <= '0;
            fall_q <= '0;
        end else begin
            cand_q <= cand_d;
            cnt_q  <= cnt_d;
            out_q  <= out_d;
            chg_q  <= chg_d;
            rise_q <= rise_d;
            fall_q <= fall_d;
        end

    assign ctrl_out  = out_q;
    assign ctrl_chg  = chg_q;
    assign ctrl_rise = rise_q;
    assign ctrl_fall = fall_q;
endmodule
